// File: rtl/fft_stage_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fft_stage_sched : radix-2 DIT FFT compute-phase butterfly/twiddle scheduler
// Revision        : 1.0
// ============================================================================
module fft_stage_sched #(
    parameter int LOG2N   = 5,
    parameter int MAX_OUT = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               bf_valid_o,
    input  logic               bf_ready_i,
    output logic [LOG2N-1:0]   addr_a_o,
    output logic [LOG2N-1:0]   addr_b_o,
    output logic [LOG2N-2:0]   tw_idx_o,
    output logic [2:0]         stage_o,
    input  logic               wb_done_i
);

    localparam int JW = LOG2N - 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [JW-1:0] J_LAST  = {JW{1'b1}};
    localparam logic [2:0]    S_LAST  = 3'(LOG2N - 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        s_q, s_d;
    logic [JW-1:0]     j_q, j_d;
    logic [OW-1:0]     out_q, out_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LOG2N-1:0]  addr_a_q, addr_a_d;
    logic [LOG2N-1:0]  addr_b_q, addr_b_d;
    logic [JW-1:0]     tw_q, tw_d;

    logic              hs_w;
    logic              wb_w;
    logic [JW-1:0]     mask_w;
    logic [JW-1:0]     pos_w;
    logic [JW-1:0]     grp_w;
    logic [LOG2N-1:0]  half_w;
    logic [LOG2N-1:0]  a_w;
    logic [2:0]        tw_sh_w;

    always_comb begin
        hs_w = valid_q & bf_ready_i;
        // Write-backs are meaningless outside a transform, so IDLE drops them.
        wb_w = wb_done_i & (state_q != S_IDLE);

        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;

        case ({hs_w, wb_w})
            2'b10:   out_d = out_q + OW'(1);
            2'b01:   out_d = (out_q == '0) ? '0 : out_q - OW'(1);
            default: out_d = out_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_ISSUE;
                    s_d     = 3'd0;
                    j_d     = '0;
                    out_d   = '0;
                end
            end
            S_ISSUE: begin
                if (hs_w) begin
                    if (j_q == J_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // Next stage reads what this stage wrote, so all write-backs must land first.
                if (out_q == '0) begin
                    if (s_q < S_LAST) begin
                        s_d     = s_q + 3'd1;
                        j_d     = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_ISSUE) && (out_d < OUT_MAX);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);

        // pos = j mod 2^s, grp = j / 2^s; the shifted mask saturates to all-ones on the last stage.
        mask_w  = ~({JW{1'b1}} << s_d);
        pos_w   = j_d & mask_w;
        grp_w   = j_d >> s_d;
        half_w  = LOG2N'(1) << s_d;
        a_w     = ({1'b0, grp_w} << (s_d + 3'd1)) | {1'b0, pos_w};
        tw_sh_w = S_LAST - s_d;

        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tw_d     = tw_q;
        if (state_d == S_ISSUE) begin
            addr_a_d = a_w;
            addr_b_d = a_w + half_w;
            tw_d     = pos_w << tw_sh_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            s_q      <= 3'd0;
            j_q      <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            j_q      <= j_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tw_q     <= tw_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign bf_valid_o = valid_q;
    assign addr_a_o   = addr_a_q;
    assign addr_b_o   = addr_b_q;
    assign tw_idx_o   = tw_q;
    assign stage_o    = s_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_fft_stage_sched : scoreboard bench for the FFT stage scheduler
// Revision           : 1.0
// ============================================================================
module tb_fft_stage_sched;

    localparam int LOG2N   = 5;
    localparam int MAX_OUT = 8;
    localparam int N       = 32;
    localparam int TOTAL   = 80;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             bf_valid_o;
    logic             bf_ready_i;
    logic [4:0]       addr_a_o;
    logic [4:0]       addr_b_o;
    logic [3:0]       tw_idx_o;
    logic [2:0]       stage_o;
    logic             wb_done_i;

    typedef struct {
        int s;
        int a;
        int b;
        int tw;
    } req_t;

    req_t exp_q[$];
    req_t hs_log[TOTAL];
    req_t mon_e;
    int   pending[$];
    int   checks, errors;
    int   cyc, hs_total, wb_total, done_count, last_s, mon_outst;
    int   wb_delay, wb_enable, release_n;
    bit   delay_s0_last;

    fft_stage_sched #(.LOG2N(LOG2N), .MAX_OUT(MAX_OUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .bf_valid_o (bf_valid_o),
        .bf_ready_i (bf_ready_i),
        .addr_a_o   (addr_a_o),
        .addr_b_o   (addr_b_o),
        .tw_idx_o   (tw_idx_o),
        .stage_o    (stage_o),
        .wb_done_i  (wb_done_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Handshake monitor: outputs are stable at the falling edge, handshake lands on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (done_o === 1'b1) done_count++;
            if (bf_valid_o === 1'b1 && bf_ready_i === 1'b1) begin
                mon_outst = hs_total - (wb_total - int'(wb_done_i));
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_extra: got s%0d a=%0d b=%0d tw=%0d, required no further issue",
                             stage_o, addr_a_o, addr_b_o, tw_idx_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (int'(stage_o) !== mon_e.s || int'(addr_a_o) !== mon_e.a ||
                        int'(addr_b_o) !== mon_e.b || int'(tw_idx_o) !== mon_e.tw) begin
                        errors++;
                        $display("FAIL issue_seq #%0d: got s%0d a=%0d b=%0d tw=%0d, required s%0d a=%0d b=%0d tw=%0d",
                                 hs_total, stage_o, addr_a_o, addr_b_o, tw_idx_o,
                                 mon_e.s, mon_e.a, mon_e.b, mon_e.tw);
                    end
                end
                checks++;
                if (mon_outst >= MAX_OUT) begin
                    errors++;
                    $display("FAIL outstanding_limit: got %0d in flight at issue, required < %0d", mon_outst, MAX_OUT);
                end
                if (int'(stage_o) != last_s) begin
                    checks++;
                    if (mon_outst != 0) begin
                        errors++;
                        $display("FAIL stage_drain: got %0d in flight at stage %0d start, required 0",
                                 mon_outst, stage_o);
                    end
                    last_s = int'(stage_o);
                end
                if (hs_total < TOTAL)
                    hs_log[hs_total] = '{int'(stage_o), int'(addr_a_o), int'(addr_b_o), int'(tw_idx_o)};
                pending.push_back(cyc + 1 + wb_delay +
                    ((delay_s0_last && stage_o == 3'd0 && addr_a_o == 5'd30) ? 20 : 0));
                hs_total++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wb_done_i = 1'b0;
        if (pending.size() > 0 && pending[0] <= cyc + 1 && (wb_enable != 0 || release_n > 0)) begin
            wb_done_i = 1'b1;
            void'(pending.pop_front());
            wb_total++;
            if (wb_enable == 0) release_n--;
        end
    endtask

    task automatic wait_hs(input int n);
        int g;
        g = 0;
        while (hs_total < n && g < 2000) begin
            tick();
            g++;
        end
        checks++;
        if (hs_total < n) begin
            errors++;
            $display("FAIL wait_issue_timeout: got %0d issues, required %0d", hs_total, n);
        end
    endtask

    task automatic start_run();
        int half;
        exp_q.delete();
        pending.delete();
        hs_total   = 0;
        wb_total   = 0;
        done_count = 0;
        last_s     = 0;
        for (int s = 0; s < LOG2N; s++) begin
            half = 1 << s;
            for (int g = 0; g < N / (2 * half); g++)
                for (int p = 0; p < half; p++)
                    exp_q.push_back('{s, g * 2 * half + p, g * 2 * half + p + half, p * (N / (2 * half))});
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (bf_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_latency: got valid=%b busy=%b one cycle after start, required 1 1", bf_valid_o, busy_o);
        end
    endtask

    task automatic finish_run();
        int g;
        g = 0;
        while (done_count == 0 && g < 2000) begin
            tick();
            g++;
        end
        checks++;
        if (done_count == 0) begin
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, required one pulse", g);
        end
        repeat (4) tick();
        checks++;
        if (done_count !== 1) begin
            errors++;
            $display("FAIL done_pulses: got %0d, required 1", done_count);
        end
        checks++;
        if (hs_total !== TOTAL) begin
            errors++;
            $display("FAIL issue_count: got %0d, required %0d", hs_total, TOTAL);
        end
        checks++;
        if (busy_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL end_state: got busy=%b unissued=%0d, required 0 0", busy_o, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if ({busy_o, done_o, bf_valid_o, addr_a_o, addr_b_o, tw_idx_o, stage_o} !== 20'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {busy_o, done_o, bf_valid_o, addr_a_o, addr_b_o, tw_idx_o, stage_o});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_run();
        start_run();
        finish_run();
        checks++;
        if (hs_log[0].s !== 0 || hs_log[0].a !== 0 || hs_log[0].b !== 1 || hs_log[0].tw !== 0) begin
            errors++;
            $display("FAIL first_issue: got s%0d a=%0d b=%0d tw=%0d, required s0 a=0 b=1 tw=0",
                     hs_log[0].s, hs_log[0].a, hs_log[0].b, hs_log[0].tw);
        end
        checks++;
        if (hs_log[19].s !== 1 || hs_log[19].a !== 5 || hs_log[19].b !== 7 || hs_log[19].tw !== 8) begin
            errors++;
            $display("FAIL s1_j3_issue: got s%0d a=%0d b=%0d tw=%0d, required s1 a=5 b=7 tw=8",
                     hs_log[19].s, hs_log[19].a, hs_log[19].b, hs_log[19].tw);
        end
        checks++;
        if (hs_log[79].s !== 4 || hs_log[79].a !== 15 || hs_log[79].b !== 31 || hs_log[79].tw !== 15) begin
            errors++;
            $display("FAIL last_issue: got s%0d a=%0d b=%0d tw=%0d, required s4 a=15 b=31 tw=15",
                     hs_log[79].s, hs_log[79].a, hs_log[79].b, hs_log[79].tw);
        end
    endtask

    task automatic test_stall();
        start_run();
        wait_hs(37);
        bf_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bf_valid_o !== 1'b1 || stage_o !== 3'd2 || addr_a_o !== 5'd9 ||
                addr_b_o !== 5'd13 || tw_idx_o !== 4'd4) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b s%0d a=%0d b=%0d tw=%0d, required v=1 s2 a=9 b=13 tw=4",
                         i, bf_valid_o, stage_o, addr_a_o, addr_b_o, tw_idx_o);
            end
        end
        bf_ready_i = 1'b1;
        finish_run();
    endtask

    task automatic test_withhold();
        wb_enable = 0;
        release_n = 0;
        start_run();
        repeat (20) tick();
        checks++;
        if (hs_total !== MAX_OUT || bf_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL withhold_limit: got issues=%0d valid=%b, required %0d 0", hs_total, bf_valid_o, MAX_OUT);
        end
        release_n = 1;
        repeat (6) tick();
        checks++;
        if (hs_total !== MAX_OUT + 1 || bf_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL release_one: got issues=%0d valid=%b, required %0d 0", hs_total, bf_valid_o, MAX_OUT + 1);
        end
        wb_enable = 1;
        finish_run();
    endtask

    task automatic test_drain_delay();
        delay_s0_last = 1'b1;
        start_run();
        wait_hs(16);
        repeat (18) tick();
        checks++;
        if (hs_total !== 16 || bf_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL drain_wait: got issues=%0d valid=%b while stage 0 write-back pending, required 16 0",
                     hs_total, bf_valid_o);
        end
        finish_run();
        delay_s0_last = 1'b0;
    endtask

    task automatic test_restart_ignored();
        start_run();
        wait_hs(51);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || stage_o !== 3'd3) begin
            errors++;
            $display("FAIL restart_ignored: got busy=%b stage=%0d, required 1 3", busy_o, stage_o);
        end
        finish_run();
    endtask

    task automatic test_async_reset();
        start_run();
        wait_hs(40);
        rst = 1'b1;
        pending.delete();
        #1;
        checks++;
        if ({busy_o, done_o, bf_valid_o, addr_a_o, addr_b_o, tw_idx_o, stage_o} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got %h before next clock, required 0",
                     {busy_o, done_o, bf_valid_o, addr_a_o, addr_b_o, tw_idx_o, stage_o});
        end
        tick();
        rst = 1'b0;
        tick();
        start_run();
        finish_run();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        hs_total      = 0;
        wb_total      = 0;
        done_count    = 0;
        last_s        = 0;
        wb_delay      = 3;
        wb_enable     = 1;
        release_n     = 0;
        delay_s0_last = 1'b0;
        rst           = 1'b1;
        start_i       = 1'b0;
        bf_ready_i    = 1'b1;
        wb_done_i     = 1'b0;

        test_reset();
        test_full_run();
        test_stall();
        test_withhold();
        test_drain_delay();
        test_restart_ignored();
        test_async_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
